control_fsm: RTL and testbench

Multicycle main controller for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback states, driving the datapath enables and multiplexer selects. It also supplies `imm_src` to the immediate extender, so the extender always sees the format matching the opcode in the instruction register.

---
 rtl/control_fsm.sv | 223 ++++++++++++++++++++++
 tb/tb_control_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// Multicycle RV32I main controller: state sequencing, datapath enables/selects and imm_src.
// Define CONTROL_FSM_ILLEGAL_TRAP_EN to trap unknown opcodes in TRAP and expose `illegal`.
module control_fsm (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_write,
    output logic        adr_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [3:0]  alu_ctrl,
    output logic [2:0]  imm_src
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    localparam logic [3:0] ST_FETCH     = 4'd0;
    localparam logic [3:0] ST_DECODE    = 4'd1;
    localparam logic [3:0] ST_MEMADR    = 4'd2;
    localparam logic [3:0] ST_MEMREAD   = 4'd3;
    localparam logic [3:0] ST_MEMWB     = 4'd4;
    localparam logic [3:0] ST_MEMWRITE  = 4'd5;
    localparam logic [3:0] ST_EXEC_R    = 4'd6;
    localparam logic [3:0] ST_EXEC_I    = 4'd7;
    localparam logic [3:0] ST_ALUWB     = 4'd8;
    localparam logic [3:0] ST_BRANCH    = 4'd9;
    localparam logic [3:0] ST_JAL       = 4'd10;
    localparam logic [3:0] ST_JALR_CALC = 4'd11;
    localparam logic [3:0] ST_LUI       = 4'd12;
    localparam logic [3:0] ST_AUIPC     = 4'd13;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    localparam logic [3:0] ST_TRAP      = 4'd14;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7b5;
    logic       w_unused_bits;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;

    assign w_opcode      = instr[6:0];
    assign w_funct3      = instr[14:12];
    assign w_funct7b5    = instr[30];
    assign w_unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    function automatic logic [3:0] f_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f_alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f_alu_op = ALU_SLL;
            3'b010:  f_alu_op = ALU_SLT;
            3'b011:  f_alu_op = ALU_SLTU;
            3'b100:  f_alu_op = ALU_XOR;
            3'b101:  f_alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f_alu_op = ALU_OR;
            default: f_alu_op = ALU_AND;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_FETCH: w_next = ST_DECODE;
            ST_DECODE: begin
                case (w_opcode)
                    OP_LOAD, OP_STORE: w_next = ST_MEMADR;
                    OP_R:              w_next = ST_EXEC_R;
                    OP_I:              w_next = ST_EXEC_I;
                    OP_BRANCH:         w_next = ST_BRANCH;
                    OP_JAL:            w_next = ST_JAL;
                    OP_JALR:           w_next = ST_JALR_CALC;
                    OP_LUI:            w_next = ST_LUI;
                    OP_AUIPC:          w_next = ST_AUIPC;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
                    default:           w_next = ST_TRAP;
`else
                    default:           w_next = ST_FETCH;
`endif
                endcase
            end
            ST_MEMADR:    w_next = instr[5] ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:   w_next = ST_MEMWB;
            ST_EXEC_R,
            ST_EXEC_I,
            ST_JAL,
            ST_LUI,
            ST_AUIPC:     w_next = ST_ALUWB;
            ST_JALR_CALC: w_next = ST_JAL;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
            ST_TRAP:      w_next = ST_TRAP;
`endif
            default:      w_next = ST_FETCH;
        endcase
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_ctrl    = ALU_ADD;
        case (r_state)
            ST_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            ST_DECODE, ST_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            ST_MEMADR, ST_JALR_CALC: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            ST_MEMREAD: adr_src = 1'b1;
            ST_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
            end
            ST_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
            end
            ST_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_ctrl  = f_alu_op(w_funct3, w_funct7b5);
            end
            ST_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                // addi has no subtract form; only the shift group honours bit 30.
                alu_ctrl  = (w_funct3 == 3'b000) ? ALU_ADD : f_alu_op(w_funct3, w_funct7b5);
            end
            ST_ALUWB: w_reg_write = 1'b1;
            ST_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_ctrl   = !w_funct3[2] ? ALU_SUB : (w_funct3[1] ? ALU_SLTU : ALU_SLT);
                w_pc_write = zero ^ w_funct3[0] ^ w_funct3[2];
            end
            ST_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                w_pc_write = 1'b1;
            end
            ST_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            default: ;
        endcase
    end

    always_comb begin
        imm_src = 3'b000;
        if (r_state != ST_FETCH) begin
            case (w_opcode)
                OP_LOAD, OP_I, OP_JALR: imm_src = 3'b010;
                OP_STORE:               imm_src = 3'b011;
                OP_BRANCH:              imm_src = 3'b100;
                OP_LUI, OP_AUIPC:       imm_src = 3'b101;
                OP_JAL:                 imm_src = 3'b110;
                default:                imm_src = 3'b000;
            endcase
        end
    end

    // Write enables are killed while reset is held so an aborted instruction commits nothing.
    assign pc_write  = w_pc_write & rstn;
    assign ir_write  = w_ir_write & rstn;
    assign reg_write = w_reg_write & rstn;
    assign mem_write = w_mem_write & rstn;

`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    assign illegal = (r_state == ST_TRAP) & rstn;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: expected per-cycle output vectors are queued with the
// stimulus and popped at each negedge sample.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        pc_write, ir_write, reg_write, mem_write, adr_src;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  alu_ctrl;
    logic [2:0]  imm_src;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    control_fsm u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .instr      (instr),
        .zero       (zero),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_ctrl   (alu_ctrl),
        .imm_src    (imm_src)
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        ,
        .illegal    (illegal)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND = 4'b0010, OR = 4'b0011;
    localparam logic [3:0] XOR = 4'b0100, SLT = 4'b0101, SLTU = 4'b0110, SLL = 4'b0111;
    localparam logic [3:0] SRL = 4'b1000, SRA = 4'b1001;

    logic [17:0] exp_q[$];
    logic [17:0] w_obs;
    int          n_pass = 0;
    int          n_total = 0;

    assign w_obs = {pc_write, ir_write, reg_write, mem_write, adr_src,
                    alu_src_a, alu_src_b, result_src, alu_ctrl, imm_src};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // {pcw, irw, regw, memw, adr, A, B, result, alu, imm}
    function automatic logic [17:0] mk(input logic pcw, input logic irw, input logic rw,
                                       input logic mw, input logic adr, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] rs,
                                       input logic [3:0] alu, input logic [2:0] imm);
        return {pcw, irw, rw, mw, adr, a, b, rs, alu, imm};
    endfunction

    function automatic logic [17:0] v_fetch();
        return mk(1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, ADD, 3'b000);
    endfunction

    function automatic logic [17:0] v_rst();
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, ADD, 3'b000);
    endfunction

    function automatic logic [17:0] v_decode(input logic [2:0] imm);
        return mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, ADD, imm);
    endfunction

    function automatic logic [17:0] v_aluwb(input logic [2:0] imm);
        return mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, ADD, imm);
    endfunction

    // Starts at a negedge in FETCH; samples n cycles, each 1 time unit after the negedge.
    task automatic run(input string tag, input logic [31:0] ins, input logic z, input int n);
        instr = ins;
        zero  = z;
        for (int i = 0; i < n; i++) begin
            #1;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL %s c%0d: got empty scoreboard, expected an entry", tag, i);
            end else begin
                check_eq($sformatf("%s c%0d", tag, i), {14'b0, w_obs}, {14'b0, exp_q.pop_front()});
            end
            @(negedge clk);
        end
    endtask

    logic [3:0]  i_alu_tab [8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
    logic [2:0]  br_f3     [8] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
    logic        br_z      [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        br_pcw    [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  br_alu    [8] = '{SUB, SUB, SUB, SUB, SLT, SLT, SLTU, SLTU};

    initial begin
        @(negedge clk);
        #1 check_eq("reset_outputs", {14'b0, w_obs}, {14'b0, v_rst()});
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);

        // lw x1,8(x2); zero held high to show it is ignored outside BRANCH
        exp_q.push_back(v_fetch());
        exp_q.push_back(v_decode(3'b010));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ADD, 3'b010));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD, 3'b010));
        exp_q.push_back(mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, ADD, 3'b010));
        run("lw", 32'h00812083, 1'b1, 5);

        // sw x1,4(x2)
        exp_q.push_back(v_fetch());
        exp_q.push_back(v_decode(3'b011));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ADD, 3'b011));
        exp_q.push_back(mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, ADD, 3'b011));
        run("sw", 32'h00112223, 1'b0, 4);

        // reset asserted while in MEMWRITE
        exp_q.push_back(v_fetch());
        exp_q.push_back(v_decode(3'b011));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ADD, 3'b011));
        run("sw_abort", 32'h00112223, 1'b0, 3);
        #1 check_eq("pre_rst_memwrite", {31'b0, mem_write}, 32'd1);
        rstn = 1'b0;
        #1 check_eq("rst_kills_memwrite", {14'b0, w_obs}, {14'b0, v_rst()});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check_eq($sformatf("rst_hold c%0d", i), {14'b0, w_obs}, {14'b0, v_rst()});
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        #1 check_eq("post_rst_fetch", {14'b0, w_obs}, {14'b0, v_fetch()});
        @(negedge clk);
        exp_q.push_back(v_decode(3'b011));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ADD, 3'b011));
        exp_q.push_back(mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, ADD, 3'b011));
        run("sw_after_rst", 32'h00112223, 1'b0, 3);

        // sub x0,x1,x2 and and x0,x1,x2
        exp_q.push_back(v_fetch());
        exp_q.push_back(v_decode(3'b000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, SUB, 3'b000));
        exp_q.push_back(v_aluwb(3'b000));
        run("sub", 32'h40208033, 1'b0, 4);
        exp_q.push_back(v_fetch());
        exp_q.push_back(v_decode(3'b000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, AND, 3'b000));
        exp_q.push_back(v_aluwb(3'b000));
        run("and", 32'h0020f033, 1'b0, 4);

        // srai, and addi with bit 30 set
        exp_q.push_back(v_fetch());
        exp_q.push_back(v_decode(3'b010));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, SRA, 3'b010));
        exp_q.push_back(v_aluwb(3'b010));
        run("srai", 32'h4030d093, 1'b0, 4);
        exp_q.push_back(v_fetch());
        exp_q.push_back(v_decode(3'b010));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ADD, 3'b010));
        exp_q.push_back(v_aluwb(3'b010));
        run("addi_b30", 32'h40008093, 1'b0, 4);

        // I-ALU funct3 sweep with bit 30 clear
        for (int f = 0; f < 8; f++) begin
            logic [31:0] ins;
            ins = {17'h00000, f[2:0], 5'd1, 7'b0010011};
            exp_q.push_back(v_fetch());
            exp_q.push_back(v_decode(3'b010));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, i_alu_tab[f], 3'b010));
            exp_q.push_back(v_aluwb(3'b010));
            run($sformatf("ialu_f%0d", f), ins, 1'b0, 4);
        end

        // branches: funct3 / zero combinations
        for (int k = 0; k < 8; k++) begin
            logic [31:0] ins;
            ins = {7'b0, 5'd2, 5'd1, br_f3[k], 5'd8, 7'b1100011};
            exp_q.push_back(v_fetch());
            exp_q.push_back(v_decode(3'b100));
            exp_q.push_back(mk(br_pcw[k], 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, br_alu[k], 3'b100));
            run($sformatf("br_f%0d_z%0d", br_f3[k], br_z[k]), ins, br_z[k], 3);
        end

        // jal, jalr
        exp_q.push_back(v_fetch());
        exp_q.push_back(v_decode(3'b110));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, ADD, 3'b110));
        exp_q.push_back(v_aluwb(3'b110));
        run("jal", 32'h008000ef, 1'b0, 4);
        exp_q.push_back(v_fetch());
        exp_q.push_back(v_decode(3'b010));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ADD, 3'b010));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, ADD, 3'b010));
        exp_q.push_back(v_aluwb(3'b010));
        run("jalr", 32'h000080e7, 1'b0, 5);

        // lui, auipc
        exp_q.push_back(v_fetch());
        exp_q.push_back(v_decode(3'b101));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, ADD, 3'b101));
        exp_q.push_back(v_aluwb(3'b101));
        run("lui", 32'h123450b7, 1'b0, 4);
        exp_q.push_back(v_fetch());
        exp_q.push_back(v_decode(3'b101));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, ADD, 3'b101));
        exp_q.push_back(v_aluwb(3'b101));
        run("auipc", 32'h00001097, 1'b0, 4);

        // unknown opcode 0x7F
        exp_q.push_back(v_fetch());
        exp_q.push_back(v_decode(3'b000));
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        run("unk", 32'h0000007f, 1'b0, 2);
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq($sformatf("trap c%0d", i), {14'b0, w_obs},
                     {14'b0, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 3'b000)});
            check_eq($sformatf("illegal c%0d", i), {31'b0, illegal}, 32'd1);
            @(negedge clk);
        end
        rstn = 1'b0;
        #1 check_eq("illegal_rst", {31'b0, illegal}, 32'd0);
        check_eq("trap_rst", {14'b0, w_obs}, {14'b0, v_rst()});
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        #1 check_eq("trap_exit_fetch", {14'b0, w_obs}, {14'b0, v_fetch()});
`else
        exp_q.push_back(v_fetch());
        run("unk", 32'h0000007f, 1'b0, 3);
`endif

        check_eq("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
